// File: rtl/ram_arb_pkg.sv
// Encodings and constants shared by the two-requester RAM arbiter.
// Pure declarations: no logic, no latency, no flow control.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        DONE  = 2'd2
    } arb_state_t;

    localparam int BANK_BIT  = 10;
    localparam int IN_BANK_W = 10;

    localparam logic REQ_M0 = 1'b0;
    localparam logic REQ_M1 = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker; combinational, zero latency.
// On a tie it favours whichever requester was not granted last; it never stalls a lone request.
module rr_pick2
    import ram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_sel
);

    always_comb begin
        grant_valid = |req;
        grant_sel   = REQ_M0;
        if (req == 2'b11) begin
            grant_sel = ~last_grant;
        end else if (req[1]) begin
            grant_sel = REQ_M1;
        end
    end

endmodule

// File: rtl/ram_arbiter_2p.sv
// Round-robin arbiter sharing two 1Kx4 RAM banks (addr bit 10 = bank) between m0 and m1.
// Grant edge to ack in 2 cycles, one op per 3 cycles; a losing requester holds req until acked.
module ram_arbiter_2p
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 m0_req,
    input  logic                 m0_we,
    input  logic [ADDR_W-1:0]    m0_addr,
    input  logic [DATA_W-1:0]    m0_wdata,
    output logic                 m0_ack,
    output logic [DATA_W-1:0]    m0_rdata,
    input  logic                 m1_req,
    input  logic                 m1_we,
    input  logic [ADDR_W-1:0]    m1_addr,
    input  logic [DATA_W-1:0]    m1_wdata,
    output logic                 m1_ack,
    output logic [DATA_W-1:0]    m1_rdata,
    output logic [IN_BANK_W-1:0] ram_addr,
    output logic [DATA_W-1:0]    ram_wdata,
    output logic                 ram_we0,
    output logic                 ram_we1,
    input  logic [DATA_W-1:0]    ram_q0,
    input  logic [DATA_W-1:0]    ram_q1,
    output logic                 busy
);

    arb_state_t          state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                op_sel_q, op_sel_d;
    logic                op_we_q, op_we_d;
    logic [ADDR_W-1:0]   op_addr_q, op_addr_d;
    logic [DATA_W-1:0]   op_wdata_q, op_wdata_d;
    logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;

    logic                grant_valid;
    logic                grant_sel;
    logic [DATA_W-1:0]   rd_nibble;

    rr_pick2 u_pick (
        .req         ({m1_req, m0_req}),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_sel   (grant_sel)
    );

    assign rd_nibble = op_addr_q[BANK_BIT] ? ram_q1 : ram_q0;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_sel_d     = op_sel_q;
        op_we_d      = op_we_q;
        op_addr_d    = op_addr_q;
        op_wdata_d   = op_wdata_q;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;
        ram_addr     = '0;
        ram_wdata    = '0;
        ram_we0      = 1'b0;
        ram_we1      = 1'b0;
        m0_ack       = 1'b0;
        m1_ack       = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    op_sel_d     = grant_sel;
                    op_we_d      = (grant_sel == REQ_M1) ? m1_we    : m0_we;
                    op_addr_d    = (grant_sel == REQ_M1) ? m1_addr  : m0_addr;
                    op_wdata_d   = (grant_sel == REQ_M1) ? m1_wdata : m0_wdata;
                    last_grant_d = grant_sel;
                    state_d      = SERVE;
                end
            end
            SERVE: begin
                ram_addr  = op_addr_q[IN_BANK_W-1:0];
                ram_wdata = op_wdata_q;
                // A reset landing on this edge must not commit the write.
                ram_we0   = ~rst & op_we_q & ~op_addr_q[BANK_BIT];
                ram_we1   = ~rst & op_we_q &  op_addr_q[BANK_BIT];
                if (!op_we_q) begin
                    if (op_sel_q == REQ_M1) begin
                        m1_rdata_d = rd_nibble;
                    end else begin
                        m0_rdata_d = rd_nibble;
                    end
                end
                state_d = DONE;
            end
            DONE: begin
                m0_ack  = ~rst & (op_sel_q == REQ_M0);
                m1_ack  = ~rst & (op_sel_q == REQ_M1);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= REQ_M1;
            op_sel_q     <= REQ_M0;
            op_we_q      <= 1'b0;
            op_addr_q    <= '0;
            op_wdata_q   <= '0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_sel_q     <= op_sel_d;
            op_we_q      <= op_we_d;
            op_addr_q    <= op_addr_d;
            op_wdata_q   <= op_wdata_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
        end
    end

    assign m0_rdata = m0_rdata_q;
    assign m1_rdata = m1_rdata_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: doc/ram_arbiter_2p.md
Name: ram_arbiter_2p

Overview:
- Round-robin arbiter and sequencer that shares the 2-bank 1Kx4 RAM (two ram_dp1_1Kx4 instances; address bit 10 selects the bank) between two requesters, m0 and m1.
- Each requester issues single-nibble read or write transactions over a req/ack handshake.
- The block registers the winning request, drives the RAM for one cycle, captures read data, and returns a one-cycle ack.
- It sits between the requesters (switch adapter, future test sequencer) and the RAM banks.

Parameters:
- ADDR_W, 11, requester address width; bit ADDR_W-1 is the bank select, bits 9:0 are the in-bank address.
- DATA_W, 4, data nibble width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- m0_req  in  1  m0 request; held high until m0_ack.
- m0_we  in  1  m0 op: 1 = write, 0 = read; stable while m0_req is high.
- m0_addr  in  ADDR_W  m0 address; stable while m0_req is high.
- m0_wdata  in  DATA_W  m0 write data; stable while m0_req is high.
- m0_ack  out  1  one-cycle completion pulse to m0.
- m0_rdata  out  DATA_W  m0 read data; valid in the m0_ack cycle and held until the next m0 read completes.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata: same as the m0 ports, for m1.
- ram_addr  out  10  shared in-bank address to both banks.
- ram_wdata  out  DATA_W  shared write data to both banks.
- ram_we0  out  1  bank-0 write enable.
- ram_we1  out  1  bank-1 write enable.
- ram_q0  in  DATA_W  bank-0 combinational read data.
- ram_q1  in  DATA_W  bank-1 combinational read data.
- busy  out  1  high while state is not IDLE.

Behaviour:
- Reset (rst high at a rising edge):
  - state = IDLE, last_grant = m1, so m0 wins the first tie.
  - All outputs = 0, including m0_rdata and m1_rdata.
- FSM states: IDLE, SERVE, DONE.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant that requester.
  - Both requesting: grant the requester that is not last_grant.
  - On a grant: latch sel, we, addr and wdata into op registers, update last_grant, go to SERVE.
- SERVE (exactly one cycle):
  - ram_addr = op_addr[9:0]; ram_wdata = op_wdata.
  - Write: ram_we0 = ~op_addr[10] & op_we; ram_we1 = op_addr[10] & op_we. The write commits at the edge ending SERVE.
  - Read: at the edge ending SERVE, capture (op_addr[10] ? ram_q1 : ram_q0) into the granted requester's rdata register. The other requester's rdata is unchanged.
  - A write does not change either rdata register.
  - Go to DONE.
- DONE (one cycle):
  - The granted requester's ack = 1; all RAM outputs return to 0.
  - Go to IDLE.
- Latency and throughput:
  - Request sampled in IDLE at edge N; ack visible in cycle N+2.
  - One transaction per 3 cycles maximum.
- Handshake rules:
  - req stays high through the ack cycle.
  - req still high in the cycle after ack is a new request.
  - Changing we/addr/wdata while req is high before ack is undefined for the requester; the arbiter uses only the values latched at grant.
- Boundary conditions:
  - Simultaneous requests: strict alternation; a continuously requesting pair yields grants m0, m1, m0, m1, ...
  - A lone requester may win back-to-back regardless of last_grant.
  - A request deasserted while not yet granted is dropped silently, with no ack.
  - Address wrap: addr 0x3FF selects bank 0 and addr 0x400 selects bank 1. No arithmetic is done on addresses.
  - Reset mid-SERVE: the write at that edge is suppressed (ram_we* forced to 0 when rst is high) and no ack is issued.
  - Reset mid-DONE: the ack is dropped.
- Outside SERVE: ram_we0 = ram_we1 = 0 and ram_addr = ram_wdata = 0.

Decomposition:
- Package ram_arb_pkg holds:
  - the state encoding (IDLE = 2'd0, SERVE = 2'd1, DONE = 2'd2);
  - BANK_BIT = 10 and IN_BANK_W = 10;
  - REQ_M0 / REQ_M1 select constants.
- Sub-module rr_pick2: combinational two-way round-robin picker.
  - Inputs: req[1:0], last_grant.
  - Outputs: grant_valid, grant_sel.
  - Instantiated once; the FSM and op registers stay in the top.

Test Plan:
- Reset then idle: assert rst for 2 cycles, no req -> every output is 0, busy = 0, no ram_we* pulse for 20 cycles.
- m0 write then m0 read: write addr 0x005, data 0xA, then read 0x005 -> ram_we0 high for exactly one cycle with ram_addr = 0x005; the read acks at N+2 with m0_rdata = 0xA; ram_we1 never rises.
- Bank select: m1 writes 0x405 = 0x3 and m0 writes 0x005 = 0xC; m1 then reads 0x405 -> ram_we1 pulses for the first write, ram_we0 for the second; m1_rdata = 0x3; m0_rdata is unchanged.
- Contention: m0 and m1 both request reads continuously for 12 cycles -> ack order m0, m1, m0, m1, exactly 3 cycles apart, and never both acks in one cycle.
- Lone requester back-to-back: only m1 requests 3 consecutive writes -> 3 m1_acks at 3-cycle spacing with no idle gap forced.
- Reset mid-SERVE: rst asserted during the SERVE cycle of a write of 0xF to 0x010 -> no ram_we pulse and no ack; a subsequent read of 0x010 returns the prior contents (0x0 from a preloaded memory).
